// File: rtl/mac_ram_pkg.sv
// Shared state encoding and default parameter values for the MAC accumulator RAM bank.
package mac_ram_pkg;

  localparam int DW_DEF   = 8;
  localparam int ACCW_DEF = 32;
  localparam int LAGW_DEF = 7;
  localparam int SAT_DEF  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    CLR   = 2'd3
  } state_t;

endpackage

// File: rtl/mac_ram_dpram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module mac_ram_dpram #(
  parameter int WIDTH = 32,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // No reset on the array so it maps onto block RAM; contents start at zero.
  logic [WIDTH-1:0] mem [2**AW] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mac_ram_bank.sv
// Per-lag multiply-accumulate bank: each sample sweep adds a_reg*b[k] into ram[k] for every lag k.
module mac_ram_bank
  import mac_ram_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int ACCW = ACCW_DEF,
  parameter int LAGW = LAGW_DEF,
  parameter int SAT  = SAT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sin,
  input  logic            clr,
  input  logic [DW-1:0]   a_in,
  input  logic [DW-1:0]   b_in,
  output logic [LAGW-1:0] lag_o,
  input  logic            rd_en,
  input  logic [LAGW-1:0] rd_addr,
  output logic [ACCW-1:0] rd_data,
  output logic            rd_valid,
  output logic            busy,
  output logic            ovf,
  output logic            overrun,
  output logic [ACCW-1:0] sample_cnt
);

  localparam logic [LAGW-1:0] K_LAST     = '1;
  localparam logic [LAGW-1:0] DRAIN_LAST = LAGW'(1);

  state_t          state, state_nx;
  logic [LAGW-1:0] k, k_nx;
  logic            sin_acc, clr_acc, rd_acc;

  logic [DW-1:0]     a_reg;
  logic              v1;
  logic [LAGW-1:0]   addr1;
  logic [2*DW-1:0]   prod1;
  logic              s2_we;
  logic [LAGW-1:0]   s2_addr;
  logic [ACCW-1:0]   s2_data;
  logic [ACCW:0]     sum;
  logic              carry;
  logic [ACCW-1:0]   sum_fix;

  logic              ram_we;
  logic [LAGW-1:0]   ram_waddr, ram_raddr;
  logic [ACCW-1:0]   ram_wdata, ram_q;
  logic [ACCW-1:0]   held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
    end
  end

  // k doubles as lag index in MAC, drain timer in DRAIN and clear address in CLR.
  always_comb begin
    state_nx = state;
    k_nx     = k;
    sin_acc  = 1'b0;
    clr_acc  = 1'b0;
    rd_acc   = 1'b0;
    case (state)
      IDLE: begin
        if (sin) begin
          sin_acc  = 1'b1;
          state_nx = MAC;
          k_nx     = '0;
        end else if (clr) begin
          clr_acc  = 1'b1;
          state_nx = CLR;
          k_nx     = '0;
        end else if (rd_en) begin
          rd_acc = 1'b1;
        end
      end
      MAC: begin
        k_nx = k + LAGW'(1);
        if (k == K_LAST) begin
          state_nx = DRAIN;
          k_nx     = '0;
        end
      end
      DRAIN: begin
        k_nx = k + LAGW'(1);
        if (k == DRAIN_LAST) begin
          state_nx = IDLE;
          k_nx     = '0;
        end
      end
      CLR: begin
        k_nx = k + LAGW'(1);
        if (k == K_LAST) begin
          state_nx = IDLE;
          k_nx     = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        k_nx     = '0;
      end
    endcase
  end

  assign busy  = (state != IDLE);
  assign lag_o = (state == MAC) ? k : '0;

  assign ram_raddr = (state == MAC) ? k : rd_addr;
  assign ram_we    = (state == CLR) || s2_we;
  assign ram_waddr = (state == CLR) ? k : s2_addr;
  assign ram_wdata = (state == CLR) ? '0 : s2_data;

  mac_ram_dpram #(
    .WIDTH (ACCW),
    .AW    (LAGW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  // The extra top bit of sum catches the carry-out that marks an overflow.
  always_comb begin
    sum     = {1'b0, ram_q} + {{(ACCW + 1 - 2*DW){1'b0}}, prod1};
    carry   = sum[ACCW];
    sum_fix = (carry && (SAT != 0)) ? '1 : sum[ACCW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      v1      <= 1'b0;
      addr1   <= '0;
      prod1   <= '0;
      s2_we   <= 1'b0;
      s2_addr <= '0;
      s2_data <= '0;
    end else begin
      if (sin_acc) a_reg <= a_in;
      v1      <= (state == MAC);
      addr1   <= k;
      prod1   <= {{DW{1'b0}}, a_reg} * {{DW{1'b0}}, b_in};
      s2_we   <= v1;
      s2_addr <= addr1;
      s2_data <= sum_fix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf        <= 1'b0;
      overrun    <= 1'b0;
      sample_cnt <= '0;
    end else if (clr_acc) begin
      ovf        <= 1'b0;
      overrun    <= 1'b0;
      sample_cnt <= '0;
    end else begin
      if (sin && busy) overrun <= 1'b1;
      if (v1 && carry) ovf <= 1'b1;
      if (state == DRAIN && k == DRAIN_LAST && sample_cnt != '1)
        sample_cnt <= sample_cnt + ACCW'(1);
    end
  end

  // rd_data shows the fresh RAM word while rd_valid is high, else the last delivered word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      held     <= '0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_valid) held <= ram_q;
    end
  end

  assign rd_data = rd_valid ? ram_q : held;

endmodule

// File: doc/mac_ram_bank.md
MAC_RAM_BANK -- requirements
Module: mac_ram_bank

Interface
REQ-001 SHALL have parameter DW, default 8: width of operands a_in, b_in (unsigned).
REQ-002 SHALL have parameter ACCW, default 32: accumulator width; legal only if ACCW >= 2*DW.
REQ-003 SHALL have parameter LAGW, default 7: address width; depth N = 2**LAGW lags.
REQ-004 SHALL have parameter SAT, default 1: 1 = saturating accumulate, 0 = wrap-around.
REQ-005 SHALL have clk  input  1  single clock, all logic rising-edge.
REQ-006 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have sin  input  1  one-cycle sample strobe starting a MAC sweep.
REQ-008 SHALL have clr  input  1  one-cycle request starting a clear sweep.
REQ-009 SHALL have a_in  input  DW  fixed operand, captured on the accepted sin.
REQ-010 SHALL have b_in  input  DW  lag operand; value for lag lag_o, valid in the same cycle.
REQ-011 SHALL have lag_o  output  LAGW  lag index whose b_in is consumed this cycle.
REQ-012 SHALL have rd_en, rd_addr  input  1, LAGW  read request and its address.
REQ-013 SHALL have rd_data, rd_valid  output  ACCW, 1  read result and its qualifier.
REQ-014 SHALL have busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have ovf, overrun  output  1, 1  sticky accumulator-overflow and dropped-sample flags.
REQ-016 SHALL have sample_cnt  output  ACCW  number of completed MAC sweeps since last clear.

Function
REQ-017 SHALL implement states IDLE, MAC, DRAIN, CLR.
REQ-018 In IDLE, priority SHALL be sin > clr > rd_en; lower-priority requests in the same cycle are discarded.
REQ-019 Accepted sin SHALL latch a_in to a_reg and enter MAC next cycle with lag counter k = 0.
REQ-020 In MAC, lag_o = k; cycle k SHALL sample b_in, issue RAM read of address k; k increments each cycle; after k = N-1 go to DRAIN.
REQ-021 Pipeline: stage 1 registers a_reg*b_in (2*DW bits, zero-extended) and RAM word; stage 2 computes sum, writes ram[k] at cycle k+2.
REQ-022 DRAIN SHALL last exactly 2 cycles, then IDLE; MAC sweep busy time = N+2 cycles.
REQ-023 Sum SHALL be computed in ACCW+1 bits; on carry-out, SAT=1 writes all-ones, SAT=0 writes low ACCW bits; both set ovf.
REQ-024 sample_cnt SHALL increment (saturating at all-ones) on DRAIN->IDLE.
REQ-025 Accepted clr SHALL enter CLR, write 0 to addresses 0..N-1 one per cycle (N cycles), then IDLE; clears ovf, overrun, sample_cnt on entry.
REQ-026 sin arriving while busy SHALL be dropped and set overrun; clr or rd_en while busy SHALL be ignored silently.
REQ-027 Accepted rd_en SHALL read ram[rd_addr]; rd_data valid with rd_valid high exactly 1 cycle later, one-cycle pulse; back-to-back reads sustain one per cycle.
REQ-028 rd_data SHALL hold its last value when rd_valid is low.
REQ-029 lag_o SHALL be 0 outside MAC.

Reset
REQ-030 rst_n low SHALL force IDLE, k = 0, a_reg = 0, busy = 0, rd_valid = 0, rd_data = 0, ovf = 0, overrun = 0, sample_cnt = 0, within any state.
REQ-031 RAM contents SHALL NOT be reset; power-up init to 0; after mid-sweep reset contents are undefined until a clear sweep.

Structure
REQ-032 Package mac_ram_pkg SHALL hold the state enum and default parameter constants.
REQ-033 Sub-module mac_ram_dpram SHALL implement the simple dual-port RAM (one write, one registered read port, block RAM inferred).
REQ-034 Read port mux: MAC uses k, IDLE uses rd_addr; write port driven by stage 2 or CLR counter.

Verification
REQ-035 Clear then sin with a_in=3, b_in=lag_o+1, N=128 -> after N+2 cycles, reads give ram[k]=3*(k+1); sample_cnt=1.
REQ-036 Two sweeps a_in=255, b_in=255 -> every word 130050, sample_cnt=2, ovf=0.
REQ-037 DW=8, ACCW=16, SAT=1, preset via sweeps until overflow -> words 65535, ovf=1; SAT=0 -> wrapped value, ovf=1.
REQ-038 sin pulse during MAC at cycle 10 -> overrun=1, sweep unaffected, sample_cnt increments once.
REQ-039 Same-cycle sin and clr in IDLE -> MAC runs, clear discarded; rd_en burst addr 0..3 -> rd_valid 4 consecutive cycles, data matches.
REQ-040 rst_n low at MAC cycle 50 -> all outputs at reset values next edge, busy=0; subsequent clr then sweep yields correct values.
